// File: rtl/cache_consts.sv
// Shared coherence-message encodings, request geometry and NoC flit field offsets.
package cache_consts;

   localparam int LINE_W = 128;
   localparam int ADDR_W = 28;

   localparam logic [1:0] COH_GETS = 2'd0;
   localparam logic [1:0] COH_GETM = 2'd1;
   localparam logic [1:0] COH_PUTS = 2'd2;
   localparam logic [1:0] COH_PUTM = 2'd3;

   // MSB positions of the header-flit fields inside the payload
   localparam int FLIT_DST_HI   = 63;
   localparam int FLIT_SRC_HI   = 59;
   localparam int FLIT_MSG_HI   = 55;
   localparam int FLIT_HPROT_HI = 53;

endpackage

// File: rtl/cache_types.sv
// Shared request struct and packetizer state type used between the L2 core and the NoC plane.
package cache_types;

   import cache_consts::*;

   typedef logic [ADDR_W-1:0] line_addr_t;
   typedef logic [LINE_W-1:0] line_t;

   typedef struct packed {
      logic [1:0] coh_msg;
      logic [1:0] hprot;
      line_addr_t addr;
      line_t      line;
   } l2_req_out_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      ADDR = 3'd2,
      DAT0 = 3'd3,
      DAT1 = 3'd4
   } pkt_state_t;

endpackage

// File: rtl/l2_req_packetizer.sv
// Turns one L2 coherence request into a 2-flit (GETS/GETM/PUTS) or 4-flit (PUTM) NoC packet.
module l2_req_packetizer
   import cache_consts::*;
   import cache_types::*;
#(
   parameter int NOC_W     = 64,
   parameter int TILE_ID_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 l2_req_out_valid,
   output logic                 l2_req_out_ready,
   input  l2_req_out_t          l2_req_out,
   input  logic [TILE_ID_W-1:0] src_tile_id,
   input  logic [TILE_ID_W-1:0] llc_tile_id,
   output logic                 noc_flit_valid,
   input  logic                 noc_flit_ready,
   output logic [NOC_W+1:0]     noc_flit,
   output logic [15:0]          pkt_cnt
);

   pkt_state_t           state_q, state_d;
   logic [1:0]           coh_q, hprot_q;
   line_addr_t           addr_q;
   line_t                line_q;
   logic [TILE_ID_W-1:0] dst_q;
   logic [15:0]          pkt_cnt_q;

   logic                 accept, fire, is_tail;
   logic                 head, tail;
   logic [NOC_W-1:0]     payload;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A tail handshake that coincides with a new accept goes straight to HDR.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = HDR;
         HDR:  if (fire)   state_d = ADDR;
         ADDR: begin
            if (fire) begin
               if (coh_q == COH_PUTM) state_d = DAT0;
               else if (accept)       state_d = HDR;
               else                   state_d = IDLE;
            end
         end
         DAT0: if (fire)   state_d = DAT1;
         DAT1: begin
            if (fire) state_d = accept ? HDR : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      noc_flit_valid   = (state_q != IDLE);
      is_tail          = ((state_q == ADDR) && (coh_q != COH_PUTM)) || (state_q == DAT1);
      fire             = noc_flit_valid && noc_flit_ready;
      l2_req_out_ready = (state_q == IDLE) || (is_tail && noc_flit_ready);
      accept           = l2_req_out_valid && l2_req_out_ready;
      head             = 1'b0;
      tail             = 1'b0;
      payload          = '0;
      case (state_q)
         HDR: begin
            head = 1'b1;
            payload[FLIT_DST_HI -: TILE_ID_W]   = dst_q;
            payload[FLIT_SRC_HI -: TILE_ID_W]   = src_tile_id;
            payload[FLIT_MSG_HI -: 2]           = coh_q;
            payload[FLIT_HPROT_HI -: 2]         = hprot_q;
         end
         ADDR: begin
            tail    = (coh_q != COH_PUTM);
            payload = NOC_W'(addr_q);
         end
         DAT0: payload = NOC_W'(line_q[LINE_W/2-1:0]);
         DAT1: begin
            tail    = 1'b1;
            payload = NOC_W'(line_q[LINE_W-1:LINE_W/2]);
         end
         default: ;
      endcase
      noc_flit = {head, tail, payload};
   end

   // Capture registers only move on accept, which keeps the presented flit stable under backpressure.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         coh_q   <= '0;
         hprot_q <= '0;
         addr_q  <= '0;
         line_q  <= '0;
         dst_q   <= '0;
      end else if (accept) begin
         coh_q   <= l2_req_out.coh_msg;
         hprot_q <= l2_req_out.hprot;
         addr_q  <= l2_req_out.addr;
         line_q  <= l2_req_out.line;
         dst_q   <= llc_tile_id;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pkt_cnt_q <= '0;
      end else if (fire && is_tail) begin
         pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
   end

   assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_l2_req_packetizer.sv
// Bench for l2_req_packetizer: directed vector table, corner sequences and a randomized run against a flit-queue model.
module tb_l2_req_packetizer;

   import cache_consts::*;
   import cache_types::*;

   localparam int NOC_W = 64;
   localparam int TW    = 4;
   localparam int FW    = NOC_W + 2;
   localparam logic [TW-1:0] SRC = 4'd2;
   localparam logic [TW-1:0] DST = 4'd5;

   logic              clk = 1'b0;
   logic              rst;
   logic              l2_req_out_valid;
   logic              l2_req_out_ready;
   l2_req_out_t       l2_req_out;
   logic [TW-1:0]     src_tile_id;
   logic [TW-1:0]     llc_tile_id;
   logic              noc_flit_valid;
   logic              noc_flit_ready;
   logic [FW-1:0]     noc_flit;
   logic [15:0]       pkt_cnt;

   always #5 clk = ~clk;

   l2_req_packetizer #(.NOC_W(NOC_W), .TILE_ID_W(TW)) dut (
      .clk              (clk),
      .rst              (rst),
      .l2_req_out_valid (l2_req_out_valid),
      .l2_req_out_ready (l2_req_out_ready),
      .l2_req_out       (l2_req_out),
      .src_tile_id      (src_tile_id),
      .llc_tile_id      (llc_tile_id),
      .noc_flit_valid   (noc_flit_valid),
      .noc_flit_ready   (noc_flit_ready),
      .noc_flit         (noc_flit),
      .pkt_cnt          (pkt_cnt)
   );

   int            n_chk  = 0;
   int            n_fail = 0;
   logic [FW-1:0] mq[$];
   logic [FW-1:0] obs[$];
   logic [15:0]   mcnt;

   typedef struct packed {
      l2_req_out_t             req;
      logic [2:0]              len;
      logic [3:0][FW-1:0]      f;
   } vec_t;

   vec_t tbl[4];

   function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endfunction

   function automatic l2_req_out_t mk_req(logic [1:0] c, logic [1:0] h, line_addr_t a, line_t l);
      l2_req_out_t r;
      r.coh_msg = c;
      r.hprot   = h;
      r.addr    = a;
      r.line    = l;
      return r;
   endfunction

   // Expected packet built straight from the flit format rules
   function automatic void push_pkt(l2_req_out_t r);
      logic is_putm;
      is_putm = (r.coh_msg == COH_PUTM);
      mq.push_back({1'b1, 1'b0, DST, SRC, r.coh_msg, r.hprot, 52'd0});
      mq.push_back({1'b0, !is_putm, 36'd0, r.addr});
      if (is_putm) begin
         mq.push_back({1'b0, 1'b0, r.line[63:0]});
         mq.push_back({1'b0, 1'b1, r.line[127:64]});
      end
   endfunction

   task automatic cycle(input logic rv, input l2_req_out_t rq, input logic nr);
      logic ev, er;
      @(negedge clk);
      l2_req_out_valid = rv;
      l2_req_out       = rq;
      noc_flit_ready   = nr;
      #1;
      ev = (mq.size() != 0);
      er = (mq.size() == 0) || ((mq.size() == 1) && nr);
      chk("flit_valid", 128'(noc_flit_valid), 128'(ev));
      chk("req_ready", 128'(l2_req_out_ready), 128'(er));
      chk("pkt_cnt", 128'(pkt_cnt), 128'(mcnt));
      if (ev) chk("flit", 128'(noc_flit), 128'(mq[0]));
      if (noc_flit_valid && nr) obs.push_back(noc_flit);
      if (ev && nr) begin
         if (mq[0][NOC_W]) mcnt++;
         mq.delete(0);
      end
      if (rv && er) push_pkt(rq);
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      while (mq.size() != 0 && k < budget) begin
         cycle(1'b0, '0, 1'b1);
         k++;
      end
      chk("drain_left", 128'(mq.size()), 128'(0));
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_valid", 128'(noc_flit_valid), 128'(0));
      chk("rst_flit", 128'(noc_flit), 128'(0));
      chk("rst_cnt", 128'(pkt_cnt), 128'(0));
      repeat (n) @(negedge clk);
      rst = 1'b1;
      mq.delete();
      obs.delete();
      mcnt = 16'd0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      l2_req_out_t gets_r, getm_r, putm_r, rq;
      rst              = 1'b0;
      l2_req_out_valid = 1'b0;
      l2_req_out       = '0;
      noc_flit_ready   = 1'b0;
      src_tile_id      = SRC;
      llc_tile_id      = DST;
      mcnt             = 16'd0;

      tbl[0].req = mk_req(COH_GETS, 2'd0, 28'h1234, '0);
      tbl[0].len = 3'd2;
      tbl[0].f   = '0;
      tbl[0].f[0] = {2'b10, 64'h5200_0000_0000_0000};
      tbl[0].f[1] = {2'b01, 64'h0000_0000_0000_1234};
      tbl[1].req = mk_req(COH_PUTM, 2'd3, 28'h0ABC,
                          {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555});
      tbl[1].len = 3'd4;
      tbl[1].f[0] = {2'b10, 64'h52F0_0000_0000_0000};
      tbl[1].f[1] = {2'b00, 64'h0000_0000_0000_0ABC};
      tbl[1].f[2] = {2'b00, 64'h5555_5555_5555_5555};
      tbl[1].f[3] = {2'b01, 64'hAAAA_AAAA_AAAA_AAAA};
      tbl[2].req = mk_req(COH_GETM, 2'd1, 28'hFFF_FFFF, '0);
      tbl[2].len = 3'd2;
      tbl[2].f   = '0;
      tbl[2].f[0] = {2'b10, 64'h5250_0000_0000_0000};
      tbl[2].f[1] = {2'b01, 64'h0000_0000_0FFF_FFFF};
      tbl[3].req = mk_req(COH_PUTS, 2'd2, 28'h0, '0);
      tbl[3].len = 3'd2;
      tbl[3].f   = '0;
      tbl[3].f[0] = {2'b10, 64'h52A0_0000_0000_0000};
      tbl[3].f[1] = {2'b01, 64'h0000_0000_0000_0000};

      do_reset(2);

      for (int i = 0; i < 4; i++) begin
         obs.delete();
         cycle(1'b1, tbl[i].req, 1'b1);
         drain(10);
         chk("tbl_len", 128'(obs.size()), 128'(tbl[i].len));
         for (int j = 0; j < int'(tbl[i].len); j++) begin
            if (j < obs.size()) chk("tbl_flit", 128'(obs[j]), 128'(tbl[i].f[j]));
         end
         cycle(1'b0, '0, 1'b1);
         chk("tbl_cnt", 128'(pkt_cnt), 128'(i + 1));
      end

      // Backpressure on the ADDR flit while a second request waits
      gets_r = mk_req(COH_GETS, 2'd0, 28'h1234, '0);
      getm_r = mk_req(COH_GETM, 2'd1, 28'h0777, '0);
      cycle(1'b1, gets_r, 1'b1);
      cycle(1'b0, '0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, getm_r, 1'b0);
         chk("stall_flit", 128'(noc_flit), 128'({2'b01, 64'h1234}));
         chk("stall_ready", 128'(l2_req_out_ready), 128'(0));
      end
      cycle(1'b1, getm_r, 1'b1);
      drain(10);

      // Back-to-back GETM packets with no idle cycle between tail and head
      obs.delete();
      for (int k = 0; k < 6; k++) begin
         cycle(1'b1, mk_req(COH_GETM, 2'd0, 28'(32'h100 + k), '0), 1'b1);
      end
      cycle(1'b0, '0, 1'b1);
      chk("b2b_flits", 128'(obs.size()), 128'(6));
      for (int j = 0; j < 6; j++) begin
         if (j < obs.size()) chk("b2b_head", 128'(obs[j][FW-1]), 128'((j % 2) == 0));
      end
      drain(10);

      // Reset while the DAT0 flit is on the wire
      putm_r = mk_req(COH_PUTM, 2'd2, 28'h0BEEF, {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888});
      cycle(1'b1, putm_r, 1'b1);
      cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b0);
      chk("dat0_flit", 128'(noc_flit), 128'({2'b00, 64'h5555_6666_7777_8888}));
      do_reset(2);
      for (int k = 0; k < 6; k++) cycle(1'b0, '0, 1'b1);
      chk("post_rst_flits", 128'(obs.size()), 128'(0));
      chk("post_rst_cnt", 128'(pkt_cnt), 128'(0));
      chk("post_rst_ready", 128'(l2_req_out_ready), 128'(1));

      // Counter wrap: preload the count to its last value, then finish one more packet
      @(negedge clk);
      force dut.pkt_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.pkt_cnt_q;
      mcnt = 16'hFFFF;
      cycle(1'b1, gets_r, 1'b1);
      drain(10);
      cycle(1'b0, '0, 1'b1);
      chk("cnt_wrap", 128'(pkt_cnt), 128'(0));

      // Randomized traffic with random backpressure
      for (int k = 0; k < 400; k++) begin
         rq = mk_req(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 28'($urandom()),
                     {$urandom(), $urandom(), $urandom(), $urandom()});
         cycle($urandom_range(0, 3) != 0, rq, $urandom_range(0, 9) < 7);
      end
      drain(50);
      cycle(1'b0, '0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
